load_store_unit: RTL and testbench
==================================

# load_store_unit

Request-queueing front end for `memory_controller`; sits between the CPU execute stage and the controller. Accepts load/store requests over a valid/ready handshake and buffers them in a small FIFO. Issues each request to the controller using its one-cycle command protocol, then returns load data, or a store-done pulse, with the request's tag.

## Interface
- `BUS_WIDTH`, default 8: address and data width; taken from the shared params package.
- `FIFO_DEPTH`, default 4: number of request-queue entries; must be a power of 2 and at least 2.
- `TAG_W`, default 2: width of the request tag.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  execute stage presents a request.
- `req_ready`  out  1  queue can accept; equals `!full`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  BUS_WIDTH  request address.
- `req_wdata`  in  BUS_WIDTH  store data; ignored for loads.
- `req_tag`  in  TAG_W  tag returned with the response.
- `mem_write_read`  out  3  command to the controller: 3'b010 write, 3'b001 read, 3'b000 none.
- `mem_addr`  out  BUS_WIDTH  address to the controller.
- `mem_wdata`  out  BUS_WIDTH  write data to the controller.
- `mem_read_data`  in  BUS_WIDTH  controller `read_data`.
- `mem_busy`  in  1  controller `busy`.
- `rsp_valid`  out  1  one-cycle pulse when load data is available.
- `rsp_data`  out  BUS_WIDTH  load data.
- `rsp_tag`  out  TAG_W  tag of the completed load.
- `wr_done`  out  1  one-cycle pulse when a store completes; `rsp_tag` carries its tag.
- `pending`  out  $clog2(FIFO_DEPTH)+1  number of queued entries plus the entry in flight.
- `proto_err`  out  1  sticky error flag; cleared only by `rst`.

## Operation
- Push occurs when `req_valid && req_ready`. There is no backpressure on responses.
- The FIFO head is popped at the end of the HOLD state.
- FSM states:
  - IDLE: drives command 000. Moves to ISSUE when the FIFO is non-empty and `mem_busy`=0.
  - ISSUE: drives 010 or 001 from the head entry for exactly one cycle, with address and write data from the head. Always moves to HOLD.
  - HOLD: drives command 000 and holds `mem_addr`/`mem_wdata` at the head values, because the RAM read is synchronous. Checks `mem_busy`:
    - `mem_busy`=1: capture `mem_read_data` and the tag into the response registers, pop the head, and move to ISSUE if the FIFO still holds an entry, else IDLE.
    - `mem_busy`=0: set `proto_err`, pop the head with no response, and go to IDLE.
- Response registers are updated at the end of HOLD. `rsp_valid` (load) or `wr_done` (store) is high for the single following cycle.
- `pending` increments on push and decrements on pop. Simultaneous push and pop leaves it unchanged.
- Full FIFO: `req_ready`=0 and pushes are ignored. A pop in the same cycle does not raise `req_ready`, because ready is based on registered occupancy.
- Pointers wrap modulo FIFO_DEPTH. The FIFO keeps one extra pointer bit to distinguish full from empty.
- Reset, including mid-transaction:
  - FIFO flushed, FSM to IDLE, in-flight entry dropped with no response.
  - All outputs 0, except `req_ready`, which is 1 (queue empty).

## Timing
- A request pushed in cycle N is driven in ISSUE at N+1 and held in HOLD at N+2. `rsp_valid`/`wr_done` is high at N+3, provided the FSM was idle and `mem_busy`=0.
- Sustained throughput is one request per 2 cycles (ISSUE, HOLD, ISSUE, ...). This matches the controller's IDLE→op→IDLE sequence.
- `mem_write_read` is non-zero only in ISSUE and never on two consecutive cycles.
- `mem_addr` is stable from ISSUE through HOLD.
- Every output except `req_ready`, `mem_*` and `pending` is a registered flop.

## Structure
- Shared params package:
  - BUS_WIDTH.
  - Command constants CMD_NONE=3'b000, CMD_WRITE=3'b010, CMD_READ=3'b001; `memory_controller` uses the same constants.
  - FSM enum `lsu_state_t` {IDLE, ISSUE, HOLD}.
- Sub-module `req_fifo`, parameterized by width and depth:
  - Registered storage, push/pop, full/empty, count.
  - Entry layout is {write, addr, wdata, tag}.
- Top level holds the FSM, the response registers and `proto_err`.

## Test plan
- Reset, then push load addr 8'h10, tag 1, with the RAM model returning 8'hA5 → `mem_write_read`=001 at N+1 only; `rsp_valid`=1, `rsp_data`=A5, `rsp_tag`=1 at N+3.
- Push store addr 8'h20, data 8'h3C, tag 2 → `mem_write_read`=010 and `mem_wdata`=3C at N+1; `wr_done`=1 and `rsp_tag`=2 at N+3; `rsp_valid` stays 0.
- Push 5 requests on back-to-back cycles → first 4 accepted, `req_ready`=0 on the 5th and `pending` reaches 4. Commands then appear every 2 cycles, responses keep FIFO order, and `pending` returns to 0.
- Controller model holds `mem_busy`=0 during HOLD → `proto_err`=1 and sticky; no `rsp_valid`; the next queued request still issues.
- Assert `rst` during HOLD of a load with 2 entries queued → no response, `pending`=0, command 000, `req_ready`=1; a fresh load after reset completes normally.
- Push and pop in the same cycle with 3 entries queued → `pending` stays 3; after 4 wraps of the pointers, data still arrives in order.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit and the memory controller it drives.
package load_store_unit_pkg;

  localparam int BUS_WIDTH = 8;

  localparam logic [2:0] CMD_NONE  = 3'b000;
  localparam logic [2:0] CMD_WRITE = 3'b010;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_fifo.sv
// Request queue: registered storage, wrap-around pointers with one extra bit for full/empty.
module req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/load_store_unit.sv
// Queues CPU load/store requests and issues them one at a time to memory_controller,
// returning load data or a store-done pulse tagged with the originating request.
module load_store_unit #(
  parameter int BUS_WIDTH  = load_store_unit_pkg::BUS_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [BUS_WIDTH-1:0]        req_addr,
  input  logic [BUS_WIDTH-1:0]        req_wdata,
  input  logic [TAG_W-1:0]            req_tag,
  output logic [2:0]                  mem_write_read,
  output logic [BUS_WIDTH-1:0]        mem_addr,
  output logic [BUS_WIDTH-1:0]        mem_wdata,
  input  logic [BUS_WIDTH-1:0]        mem_read_data,
  input  logic                        mem_busy,
  output logic                        rsp_valid,
  output logic [BUS_WIDTH-1:0]        rsp_data,
  output logic [TAG_W-1:0]            rsp_tag,
  output logic                        wr_done,
  output logic [$clog2(FIFO_DEPTH):0] pending,
  output logic                        proto_err
);

  import load_store_unit_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic                 write;
    logic [BUS_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0] wdata;
    logic [TAG_W-1:0]     tag;
  } req_t;

  lsu_state_t r_state, w_next;
  req_t       w_in, w_head;
  logic       w_push, w_pop, w_full, w_empty;
  logic [CW-1:0] w_count;
  logic [2:0] w_cmd;

  logic                 r_rsp_valid, r_wr_done, r_proto_err;
  logic [BUS_WIDTH-1:0] r_rsp_data;
  logic [TAG_W-1:0]     r_rsp_tag;

  assign w_in   = '{write: req_write, addr: req_addr, wdata: req_wdata, tag: req_tag};
  assign w_push = req_valid && !w_full;

  req_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // IDLE looks at the incoming push so a request issues the cycle after it is accepted.
  always_comb begin
    w_next = r_state;
    w_cmd  = CMD_NONE;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: begin
        if ((!w_empty || w_push) && !mem_busy) w_next = ISSUE;
      end
      ISSUE: begin
        w_cmd  = w_head.write ? CMD_WRITE : CMD_READ;
        w_next = HOLD;
      end
      HOLD: begin
        w_pop = 1'b1;
        if (mem_busy && ((w_count > CW'(1)) || w_push)) w_next = ISSUE;
        else                                            w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_wr_done   <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_tag   <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_wr_done   <= 1'b0;
      if (r_state == HOLD) begin
        if (mem_busy) begin
          r_rsp_valid <= !w_head.write;
          r_wr_done   <= w_head.write;
          r_rsp_data  <= mem_read_data;
          r_rsp_tag   <= w_head.tag;
        end else begin
          r_proto_err <= 1'b1;
        end
      end
    end
  end

  assign req_ready      = !w_full;
  assign mem_write_read = w_cmd;
  assign mem_addr       = (r_state != IDLE) ? w_head.addr  : '0;
  assign mem_wdata      = (r_state != IDLE) ? w_head.wdata : '0;
  assign pending        = w_count;
  assign rsp_valid      = r_rsp_valid;
  assign wr_done        = r_wr_done;
  assign rsp_data       = r_rsp_data;
  assign rsp_tag        = r_rsp_tag;
  assign proto_err      = r_proto_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against an in-order queue model
// and a simple synchronous-RAM controller model.
module tb_load_store_unit;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic [1:0] req_tag;
  logic [2:0] mem_write_read;
  logic [7:0] mem_addr, mem_wdata, mem_read_data;
  logic       mem_busy;
  logic       rsp_valid, wr_done, proto_err;
  logic [7:0] rsp_data;
  logic [1:0] rsp_tag;
  logic [2:0] pending;

  logic       r_busy, force_busy, suppress;
  logic [7:0] ram [256];
  logic [7:0] ref_ram [256];

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [1:0] tag;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   model_cnt, cyc;
  logic prev_cmd_nz, prev_proto;
  logic [7:0] held_addr, held_wdata;

  load_store_unit #(.BUS_WIDTH(8), .FIFO_DEPTH(DEPTH), .TAG_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .mem_write_read(mem_write_read), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read_data(mem_read_data), .mem_busy(mem_busy),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .wr_done(wr_done), .pending(pending), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    return (i == 16) ? 8'hA5 : 8'(i * 7 + 3);
  endfunction

  // Controller: busy for the cycle after a command; read data appears one cycle later.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      r_busy        <= 1'b0;
      mem_read_data <= 8'h00;
    end else if (mem_write_read == 3'b010) begin
      ram[mem_addr] <= mem_wdata;
      r_busy        <= 1'b1;
    end else if (mem_write_read == 3'b001) begin
      mem_read_data <= ram[mem_addr];
      r_busy        <= 1'b1;
    end else begin
      r_busy <= 1'b0;
    end
  end

  assign mem_busy = (r_busy | force_busy) & ~suppress;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic set_req(input logic v, input logic w, input logic [7:0] a,
                         input logic [7:0] d, input logic [1:0] t);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_tag = t;
  endtask

  task automatic tick();
    logic acc;
    exp_t e;
    chk("req_ready", 32'(req_ready), 32'(model_cnt < DEPTH));
    acc = req_valid && (model_cnt < DEPTH);
    if (acc) begin
      e.wr = req_write; e.addr = req_addr; e.wdata = req_wdata; e.tag = req_tag;
      e.data = req_write ? 8'h00 : ref_ram[req_addr];
      if (req_write) ref_ram[req_addr] = req_wdata;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    cyc++;
    if (acc) model_cnt++;
    if (prev_cmd_nz) begin
      chk("hold_cmd", 32'(mem_write_read), 32'(0));
      chk("hold_addr", 32'(mem_addr), 32'(held_addr));
      chk("hold_wdata", 32'(mem_wdata), 32'(held_wdata));
    end
    if (rsp_valid || wr_done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rsp", 32'({rsp_valid, wr_done}), 32'(0));
      end else begin
        e = exp_q.pop_front();
        model_cnt--;
        chk("rsp_kind", 32'({wr_done, rsp_valid}), e.wr ? 32'(2) : 32'(1));
        chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
        if (!e.wr) chk("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
    if (proto_err && !prev_proto && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      model_cnt--;
    end
    prev_proto = proto_err;
    if (mem_write_read != 3'b000) begin
      if (exp_q.size() == 0) begin
        chk("spurious_cmd", 32'(mem_write_read), 32'(0));
      end else begin
        chk("cmd", 32'(mem_write_read), exp_q[0].wr ? 32'(2) : 32'(1));
        chk("cmd_addr", 32'(mem_addr), 32'(exp_q[0].addr));
        if (exp_q[0].wr) chk("cmd_wdata", 32'(mem_wdata), 32'(exp_q[0].wdata));
      end
    end
    prev_cmd_nz = (mem_write_read != 3'b000);
    held_addr   = mem_addr;
    held_wdata  = mem_wdata;
    chk("pending", 32'(pending), 32'(model_cnt));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((model_cnt != 0 || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_cnt", 32'(model_cnt), 32'(0));
    chk("drain_q", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_ready", 32'(req_ready), 32'(1));
    chk("rst_pending", 32'(pending), 32'(0));
    chk("rst_cmd", 32'(mem_write_read), 32'(0));
    chk("rst_flags", 32'({rsp_valid, wr_done, proto_err}), 32'(0));
    chk("rst_addr", 32'({mem_addr, mem_wdata}), 32'(0));
    chk("rst_rsp", 32'({rsp_data, rsp_tag}), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    prev_cmd_nz = 1'b0;
    prev_proto = 1'b0;
    for (int i = 0; i < 256; i++) ref_ram[i] = init_val(i);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int last, ncmd;
    set_req(1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
    force_busy = 1'b0; suppress = 1'b0;
    cyc = 0;
    do_reset();

    // Single load
    set_req(1'b1, 1'b0, 8'h10, 8'h00, 2'd1);
    tick();
    chk("t1_cmd", 32'(mem_write_read), 32'(1));
    chk("t1_addr", 32'(mem_addr), 32'(8'h10));
    req_valid = 1'b0;
    tick();
    chk("t1_hold_cmd", 32'(mem_write_read), 32'(0));
    tick();
    chk("t1_rsp", 32'({rsp_valid, rsp_data, rsp_tag}), 32'({1'b1, 8'hA5, 2'd1}));
    tick();
    chk("t1_pulse", 32'(rsp_valid), 32'(0));

    // Single store
    set_req(1'b1, 1'b1, 8'h20, 8'h3C, 2'd2);
    tick();
    chk("t2_cmd", 32'({mem_write_read, mem_wdata}), 32'({3'b010, 8'h3C}));
    req_valid = 1'b0;
    tick();
    tick();
    chk("t2_done", 32'({wr_done, rsp_valid, rsp_tag}), 32'({1'b1, 1'b0, 2'd2}));
    tick();

    // Burst of 5 against a stalled controller
    force_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_req(1'b1, 1'(k % 2), 8'(8'h20 + k), 8'($urandom), 2'(k));
      if (k == 4) chk("burst_ready5", 32'(req_ready), 32'(0));
      tick();
    end
    chk("burst_pending", 32'(pending), 32'(4));
    req_valid = 1'b0;
    force_busy = 1'b0;
    last = -1; ncmd = 0;
    for (int n = 0; n < 40 && (model_cnt != 0 || exp_q.size() != 0); n++) begin
      tick();
      if (mem_write_read != 3'b000) begin
        if (last >= 0) chk("burst_gap", 32'(cyc - last), 32'(2));
        last = cyc;
        ncmd++;
      end
    end
    chk("burst_ncmd", 32'(ncmd), 32'(4));
    chk("burst_empty", 32'(pending), 32'(0));

    // Controller drops busy during HOLD
    set_req(1'b1, 1'b0, 8'h05, 8'h00, 2'd0);
    tick();
    set_req(1'b1, 1'b0, 8'h06, 8'h00, 2'd3);
    tick();
    req_valid = 1'b0;
    suppress = 1'b1;
    tick();
    suppress = 1'b0;
    chk("perr_set", 32'({proto_err, rsp_valid}), 32'({1'b1, 1'b0}));
    drain(20);
    chk("perr_sticky", 32'(proto_err), 32'(1));

    // Reset during HOLD with two more entries queued
    force_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_req(1'b1, 1'b0, 8'(8'h30 + k), 8'h00, 2'(k));
      tick();
    end
    req_valid = 1'b0;
    force_busy = 1'b0;
    tick();
    tick();
    do_reset();
    chk("mrst_quiet", 32'({rsp_valid, wr_done, mem_write_read}), 32'(0));
    set_req(1'b1, 1'b0, 8'h10, 8'h00, 2'd2);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("mrst_load", 32'({rsp_valid, rsp_data, rsp_tag}), 32'({1'b1, 8'hA5, 2'd2}));
    tick();

    // Simultaneous push and pop with three queued
    force_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_req(1'b1, 1'(k == 1), 8'(8'h40 + k), 8'($urandom), 2'(k));
      tick();
    end
    req_valid = 1'b0;
    tick();
    chk("pp_before", 32'(pending), 32'(3));
    force_busy = 1'b0;
    tick();
    tick();
    set_req(1'b1, 1'b0, 8'h40, 8'h00, 2'd3);
    tick();
    chk("pp_same", 32'(pending), 32'(3));
    req_valid = 1'b0;
    drain(30);

    // Random traffic over a small address window so loads observe earlier stores
    for (int n = 0; n < 100; n++) begin
      set_req($urandom_range(0, 99) < 60, 1'($urandom), 8'($urandom_range(0, 15)),
              8'($urandom), 2'($urandom));
      tick();
    end
    req_valid = 1'b0;
    drain(60);
    chk("final_perr", 32'(proto_err), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
